// File: rtl/pad_arb_pkg.sv
// Shared constants and types for the pad link arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pad_arb_pkg;

  localparam int N_LINK_DEFAULT = 4;
  localparam int DATA_W_DEFAULT = 116;

  // Pad frame layout: BCID on top, hit map below it.
  localparam int BCID_MSB = 115;
  localparam int BCID_LSB = 104;
  localparam int HIT_MSB  = 103;
  localparam int HIT_LSB  = 0;
  localparam int HIT_W    = HIT_MSB - HIT_LSB + 1;

  // Link indices fit 3 bits (up to 8 links).
  localparam int LINK_ID_W = 3;

  localparam int BREAK_CNT_W = 16;
  localparam int DROP_CNT_W  = 8;
  localparam logic [BREAK_CNT_W-1:0] BREAK_CNT_MAX = '1;
  localparam logic [DROP_CNT_W-1:0]  DROP_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pad_rr_arbiter.sv
// Round-robin grant over occupied holding registers, search starts after last_grant.
// Latency: combinational.
// Backpressure: none here; the caller decides whether the grant is taken.
// Ports: req (occupied mask), last_grant (previous winner) in;
//        grant (one-hot), grant_idx (winner index), grant_any (some request) out.
module pad_rr_arbiter
  import pad_arb_pkg::*;
#(
  parameter int N = N_LINK_DEFAULT
) (
  input  logic [N-1:0]         req,
  input  logic [LINK_ID_W-1:0] last_grant,
  output logic [N-1:0]         grant,
  output logic [LINK_ID_W-1:0] grant_idx,
  output logic                 grant_any
);

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_grant is the one left standing.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = N; off >= 1; off--) begin
      for (int j = 0; j < N; j++) begin
        if (req[j] && (j == (int'(last_grant) + off) % N)) begin
          grant     = '0;
          grant[j]  = 1'b1;
          grant_idx = LINK_ID_W'(j);
          grant_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pad_link_arbiter.sv
// Merges N_LINK pad links into one valid/ready stream with per-link health counters.
// Latency: strobe sampled at edge k+1 loads the holding register, out_valid after edge k+2.
// Backpressure: out_ready low stalls the output register; a full un-freed holding register drops new hits.
// Ports: clk160/reset; enable (capture gate); pad_data_in/pad_data_valid/linked per link;
//        clear_link_error (rising edge clears counters); out_valid/out_ready/out_data/out_link_id;
//        state (FSM); break_cnt/drop_cnt (packed per-link saturating counters).
module pad_link_arbiter
  import pad_arb_pkg::*;
#(
  parameter int N_LINK = N_LINK_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                          clk160,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [N_LINK*DATA_W-1:0]      pad_data_in,
  input  logic [N_LINK-1:0]             pad_data_valid,
  input  logic [N_LINK-1:0]             linked,
  input  logic                          clear_link_error,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [LINK_ID_W-1:0]          out_link_id,
  output logic [1:0]                    state,
  output logic [N_LINK*BREAK_CNT_W-1:0] break_cnt,
  output logic [N_LINK*DROP_CNT_W-1:0]  drop_cnt
);

  arb_state_t             st;
  logic [N_LINK-1:0]      hold_vld;
  logic [DATA_W-1:0]      hold_dat [N_LINK];
  logic [LINK_ID_W-1:0]   last_grant;
  logic [N_LINK-1:0]      linked_prev;
  logic                   clear_prev;
  logic [BREAK_CNT_W-1:0] brk [N_LINK];
  logic [DROP_CNT_W-1:0]  drp [N_LINK];

  logic [N_LINK-1:0]      hit;
  logic [N_LINK-1:0]      grant;
  logic [N_LINK-1:0]      take;
  logic [N_LINK-1:0]      load;
  logic [N_LINK-1:0]      drop;
  logic [N_LINK-1:0]      fall;
  logic [LINK_ID_W-1:0]   grant_idx;
  logic                   grant_any;
  logic                   out_free;
  logic                   capture;
  logic                   clear_rise;
  logic                   all_empty;
  logic [DATA_W-1:0]      grant_dat;

  // A frame only counts when strobed on a locked link and carrying at least one hit.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_LINK; i++) begin
      hit[i] = pad_data_valid[i] & linked[i]
             & (|pad_data_in[i*DATA_W + HIT_LSB +: HIT_W]);
    end
  end

  pad_rr_arbiter #(.N(N_LINK)) u_rr (
    .req        (hold_vld),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  // Output register can take a frame when empty or being drained this cycle.
  assign out_free   = ~out_valid | out_ready;
  assign take       = grant & {N_LINK{out_free}};
  assign capture    = (st == ST_RUN);
  // A register freed by this cycle's grant can be refilled in the same cycle.
  assign load       = {N_LINK{capture}} & hit & (~hold_vld | take);
  assign drop       = {N_LINK{capture}} & hit & hold_vld & ~take;
  assign fall       = linked_prev & ~linked;
  assign clear_rise = clear_link_error & ~clear_prev;
  assign all_empty  = ~(|hold_vld) & ~out_valid;

  always_comb begin
    grant_dat = '0;
    for (int j = 0; j < N_LINK; j++) begin
      if (grant[j]) grant_dat = hold_dat[j];
    end
  end

  always_ff @(posedge clk160) begin
    if (reset) begin
      hold_vld <= '0;
      for (int i = 0; i < N_LINK; i++) hold_dat[i] <= '0;
    end else begin
      for (int i = 0; i < N_LINK; i++) begin
        if (load[i]) begin
          hold_vld[i] <= 1'b1;
          hold_dat[i] <= pad_data_in[i*DATA_W +: DATA_W];
        end else if (take[i]) begin
          hold_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk160) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_link_id <= '0;
      last_grant  <= LINK_ID_W'(N_LINK - 1);
    end else if (grant_any && out_free) begin
      out_valid   <= 1'b1;
      out_data    <= grant_dat;
      out_link_id <= grant_idx;
      last_grant  <= grant_idx;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // DRAIN keeps arbitrating and emitting; it only idles once nothing is left.
  always_ff @(posedge clk160) begin
    if (reset) begin
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:  if (enable) st <= ST_RUN;
        ST_RUN:   if (!enable) st <= ST_DRAIN;
        ST_DRAIN: begin
          if (enable)         st <= ST_RUN;
          else if (all_empty) st <= ST_IDLE;
        end
        default:  st <= ST_IDLE;
      endcase
    end
  end

  assign state = st;

  // Clear takes priority over any increment landing in the same cycle.
  always_ff @(posedge clk160) begin
    if (reset) begin
      linked_prev <= '0;
      clear_prev  <= 1'b0;
      for (int i = 0; i < N_LINK; i++) begin
        brk[i] <= '0;
        drp[i] <= '0;
      end
    end else begin
      linked_prev <= linked;
      clear_prev  <= clear_link_error;
      for (int i = 0; i < N_LINK; i++) begin
        if (clear_rise) begin
          brk[i] <= '0;
          drp[i] <= '0;
        end else begin
          if (fall[i] && brk[i] != BREAK_CNT_MAX) brk[i] <= brk[i] + BREAK_CNT_W'(1);
          if (drop[i] && drp[i] != DROP_CNT_MAX)  drp[i] <= drp[i] + DROP_CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    break_cnt = '0;
    drop_cnt  = '0;
    for (int i = 0; i < N_LINK; i++) begin
      break_cnt[i*BREAK_CNT_W +: BREAK_CNT_W] = brk[i];
      drop_cnt[i*DROP_CNT_W +: DROP_CNT_W]    = drp[i];
    end
  end

endmodule

// File: tb/tb_pad_link_arbiter.sv
// Directed scenarios plus a random run, every cycle compared against a
// frame-level reference model of the arbiter's rules.
module tb_pad_link_arbiter;

  localparam int N = 4;
  localparam int W = 116;

  logic             clk160;
  logic             reset;
  logic             enable;
  logic [N*W-1:0]   pad_data_in;
  logic [N-1:0]     pad_data_valid;
  logic [N-1:0]     linked;
  logic             clear_link_error;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [2:0]       out_link_id;
  logic [1:0]       state;
  logic [N*16-1:0]  break_cnt;
  logic [N*8-1:0]   drop_cnt;

  pad_link_arbiter #(.N_LINK(N), .DATA_W(W)) dut (
    .clk160           (clk160),
    .reset            (reset),
    .enable           (enable),
    .pad_data_in      (pad_data_in),
    .pad_data_valid   (pad_data_valid),
    .linked           (linked),
    .clear_link_error (clear_link_error),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_link_id      (out_link_id),
    .state            (state),
    .break_cnt        (break_cnt),
    .drop_cnt         (drop_cnt)
  );

  initial clk160 = 1'b0;
  always #5 clk160 = ~clk160;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-link slot, one output slot, round-robin pointer.
  int           m_state, m_last, m_oid;
  bit           m_ov;
  logic [W-1:0] m_od;
  bit           m_hv [N];
  logic [W-1:0] m_hd [N];
  bit           m_lq [N];
  bit           m_clrq;
  int           m_brk [N];
  int           m_drp [N];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_last = N - 1; m_ov = 0; m_od = '0; m_oid = 0; m_clrq = 0;
    for (int i = 0; i < N; i++) begin
      m_hv[i] = 0; m_hd[i] = '0; m_lq[i] = 0; m_brk[i] = 0; m_drp[i] = 0;
    end
  endtask

  // Advances the model by one clock using the inputs seen at that edge.
  task automatic model_step();
    int g, c;
    bit empty_all, clr, hit;
    bit n_hv [N];
    logic [W-1:0] n_hd [N];
    logic [W-1:0] f;
    if (reset) begin
      model_reset();
      return;
    end
    empty_all = !m_ov;
    for (int i = 0; i < N; i++) if (m_hv[i]) empty_all = 0;
    g = -1;
    if (!m_ov || out_ready) begin
      for (int off = 1; off <= N; off++) begin
        c = (m_last + off) % N;
        if (m_hv[c]) begin
          g = c;
          break;
        end
      end
    end
    clr = clear_link_error && !m_clrq;
    for (int i = 0; i < N; i++) begin
      f = pad_data_in[i*W +: W];
      hit = pad_data_valid[i] && linked[i] && (f[103:0] != '0);
      n_hv[i] = m_hv[i] && (g != i);
      n_hd[i] = m_hd[i];
      if (m_state == 1 && hit) begin
        if (n_hv[i]) begin
          if (m_drp[i] < 255) m_drp[i]++;
        end else begin
          n_hv[i] = 1;
          n_hd[i] = f;
        end
      end
      if (m_lq[i] && !linked[i] && m_brk[i] < 65535) m_brk[i]++;
      if (clr) begin
        m_brk[i] = 0;
        m_drp[i] = 0;
      end
      m_lq[i] = linked[i];
    end
    m_clrq = clear_link_error;
    if (g >= 0) begin
      m_ov = 1; m_od = m_hd[g]; m_oid = g; m_last = g;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (m_state == 0 && enable) m_state = 1;
    else if (m_state == 1 && !enable) m_state = 2;
    else if (m_state == 2 && enable) m_state = 1;
    else if (m_state == 2 && empty_all) m_state = 0;
    for (int i = 0; i < N; i++) begin
      m_hv[i] = n_hv[i];
      m_hd[i] = n_hd[i];
    end
  endtask

  task automatic check_all();
    chk("state", state, m_state);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_link_id", out_link_id, m_oid);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("break_cnt[%0d]", i), break_cnt[i*16 +: 16], m_brk[i]);
      chk($sformatf("drop_cnt[%0d]", i), drop_cnt[i*8 +: 8], m_drp[i]);
    end
  endtask

  // Inputs change only after the falling edge; outputs are read there too.
  task automatic tick();
    @(posedge clk160);
    model_step();
    @(negedge clk160);
    check_all();
  endtask

  task automatic set_frame(input int i, input logic [11:0] bcid, input logic [103:0] hits);
    pad_data_in[i*W +: W] = {bcid, hits};
    pad_data_valid[i] = 1'b1;
  endtask

  int n_out;

  initial begin
    reset = 1'b1; enable = 1'b0; pad_data_in = '0; pad_data_valid = '0;
    linked = '1; clear_link_error = 1'b0; out_ready = 1'b0;
    model_reset();
    tick(); tick();
    chk("rst_state", state, 2'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_break_cnt", break_cnt, '0);

    // Four links strobe together: one frame per cycle in link order.
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    tick();
    chk("run_state", state, 2'd1);
    for (int i = 0; i < N; i++) set_frame(i, 12'h010 + 12'(i), 104'h1 << i);
    tick();
    pad_data_valid = '0;
    chk("s1_not_yet_valid", out_valid, 1'b0);
    for (int i = 0; i < N; i++) begin
      tick();
      chk("s1_valid", out_valid, 1'b1);
      chk("s1_link_id", out_link_id, i);
      chk("s1_bcid", out_data[115:104], 12'h010 + 12'(i));
    end
    tick();
    chk("s1_done", out_valid, 1'b0);

    // Output stalled: 0x020 moves into the empty output register (freeing
    // the link-1 slot, so 0x021 is absorbed); 0x022 then finds the slot full.
    out_ready = 1'b0;
    set_frame(1, 12'h020, 104'hA5); tick();
    set_frame(1, 12'h021, 104'hA5); tick();
    set_frame(1, 12'h022, 104'hA5); tick();
    pad_data_valid = '0;
    chk("s2_drop_cnt1", drop_cnt[8 +: 8], 8'd1);
    for (int k = 0; k < 5; k++) begin
      chk("s2_hold_valid", out_valid, 1'b1);
      chk("s2_hold_bcid", out_data[115:104], 12'h020);
      chk("s2_hold_link", out_link_id, 3'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("s2_next_bcid", out_data[115:104], 12'h021);
    tick();
    chk("s2_empty", out_valid, 1'b0);

    // Non-hit frames: empty hit map, then an unlocked link.
    set_frame(2, 12'h030, '0); tick();
    pad_data_valid = '0;
    linked[2] = 1'b0;
    set_frame(2, 12'h031, 104'hF); tick();
    pad_data_valid = '0;
    for (int k = 0; k < 3; k++) begin
      chk("s3_no_valid", out_valid, 1'b0);
      tick();
    end
    chk("s3_drop_cnt2", drop_cnt[16 +: 8], 8'd0);
    linked[2] = 1'b1;
    tick();

    // Link breaks, then a clear edge landing on a fourth break.
    for (int k = 0; k < 3; k++) begin
      linked[0] = 1'b0; tick();
      linked[0] = 1'b1; tick();
    end
    chk("s4_break_cnt0", break_cnt[0 +: 16], 16'd3);
    chk("s4_break_cnt2", break_cnt[32 +: 16], 16'd1);
    linked[0] = 1'b0; clear_link_error = 1'b1;
    tick();
    linked[0] = 1'b1;
    chk("s4_cleared_break0", break_cnt[0 +: 16], 16'd0);
    chk("s4_cleared_drop1", drop_cnt[8 +: 8], 8'd0);
    clear_link_error = 1'b0;
    tick();

    // Drain: two frames held, capture stops, both still come out.
    out_ready = 1'b0;
    set_frame(0, 12'h040, 104'h1);
    set_frame(3, 12'h043, 104'h2);
    tick();
    pad_data_valid = '0;
    enable = 1'b0;
    tick();
    chk("s5_drain_state", state, 2'd2);
    out_ready = 1'b1;
    n_out = 0;
    for (int k = 0; k < 20 && state != 2'd0; k++) begin
      if (out_valid) n_out++;
      tick();
    end
    chk("s5_idle_state", state, 2'd0);
    chk("s5_frames_out", n_out, 2);
    set_frame(1, 12'h050, 104'h1); tick();
    pad_data_valid = '0;
    tick(); tick();
    chk("s5_idle_ignored", out_valid, 1'b0);

    // Reset during a stalled transfer.
    enable = 1'b1; out_ready = 1'b0;
    tick();
    linked[3] = 1'b0;
    set_frame(2, 12'h060, 104'h1); tick();
    pad_data_valid = '0; linked[3] = 1'b1;
    tick();
    chk("s6_stalled_valid", out_valid, 1'b1);
    chk("s6_break_cnt3", break_cnt[48 +: 16], 16'd1);
    reset = 1'b1;
    tick();
    chk("s6_rst_valid", out_valid, 1'b0);
    chk("s6_rst_state", state, 2'd0);
    chk("s6_rst_break", break_cnt, '0);
    chk("s6_rst_drop", drop_cnt, '0);
    reset = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("s6_no_replay", out_valid, 1'b0);

    // Random traffic against the model.
    enable = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [127:0] r;
      if ($urandom_range(0, 31) == 0) enable = ~enable;
      if ($urandom_range(0, 31) == 0) clear_link_error = ~clear_link_error;
      out_ready = ($urandom_range(0, 3) != 0);
      reset = (cyc == 200);
      for (int i = 0; i < N; i++) begin
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) r[103:0] = '0;
        pad_data_in[i*W +: W] = r[W-1:0];
        pad_data_valid[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) linked[i] = ~linked[i];
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
